nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit for the KGP-miniRISC ALU.
- Sits directly upstream of the team's 4-bit CLA slice, carry_look_adder, and instantiates exactly one of it.
- Each cycle it feeds the slice one operand nibble plus the running carry, then captures the slice's sum nibble and carry-out.
- Trades latency for area on the low-cost ALU configuration.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 4 and at least 8. N = WIDTH/4 nibbles.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- op_sub  input  1  1 = a - b, 0 = a + b + cin.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when op_sub=1.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  carry-out of the MSB nibble (for subtract, 1 = no borrow).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand registers, carry register and nibble counter are all 0.
- States: IDLE, RUN, DONE.
- Accept (IDLE or DONE, start=1 at edge E0):
  - Latch A=a.
  - Latch B = op_sub ? ~b : b.
  - Latch carry = op_sub ? 1 : cin.
  - cnt=0; go to RUN; busy=1 from E0.
- RUN, each cycle k = 0..N-1:
  - Slice inputs are A[4k+3:4k], B[4k+3:4k] and carry.
  - At the edge, write the slice sum to sum[4k+3:4k], load carry with the slice carry-out, and increment cnt.
  - Implementation may shift A/B right by 4 instead of muxing; the visible result is identical.
- Sum bits above the current nibble keep their previous values until written. Sum is only guaranteed valid when done=1.
- Last nibble (k=N-1):
  - At that edge, cout=final carry; go to DONE.
  - busy=0 and done=1 for exactly one cycle, which is the cycle after edge E0+N.
  - Latency is N+1 edges from accept to the done cycle.
- DONE:
  - start=1 → accepted as in IDLE (back-to-back); done is still high that cycle and drops next cycle.
  - start=0 → IDLE.
  - sum and cout hold in both cases.
- start while busy: ignored. No queueing, no error.
- Inputs a/b/op_sub/cin are don't-care except at the accept edge.
- Reset mid-operation: immediate abort to reset values. The partial result is discarded and no done is issued.
- Carry-in for an add is the raw cin. Subtract is two's complement (A + ~B + 1).
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_FLAGS_EN.
- Defined → adds outputs zero (1 bit) and ovf (1 bit), updated at the same edge as cout and held with sum; both reset to 0.
  - zero = (final sum == 0). Track it as a sticky OR of nibbles during RUN, not as a wide compare.
  - ovf = signed overflow = carry into MSB XOR carry out of MSB. Capture the MSB nibble's internal carry as A[W-1] ^ B[W-1] ^ sum[W-1].
- Undefined → ports absent, no flag logic.

Test Plan (WIDTH=32, N=8):
- Full carry chain: a=32'h0000_0001, b=32'hFFFF_FFFF, cin=0, op_sub=0, start pulse → busy for 8 cycles, then done=1 with sum=32'h0000_0000, cout=1; zero=1, ovf=0 if FLAGS_EN.
- Subtract with borrow: a=5, b=7, op_sub=1 → sum=32'hFFFF_FFFE, cout=0; ovf=0. Also a=7, b=5 → sum=2, cout=1.
- Signed overflow (FLAGS_EN): a=32'h7FFF_FFFF, b=1, cin=0 → sum=32'h8000_0000, cout=0, ovf=1, zero=0. Then cin=1 with a=b=0 → sum=1.
- Start ignored while busy: accept a=1, b=2; pulse start with a=100, b=100 at RUN cycle 3 → single done, sum=3, no second done.
- Back-to-back: assert start with a=10, b=20 in the DONE cycle of a prior op → new op accepted, busy next cycle, done 9 cycles later with sum=30. The prior sum stays visible until overwritten.
- Reset mid-op: rst_n=0 at RUN cycle 4 → busy=0, done=0, sum=0, cout=0 asynchronously, with no done pulse afterwards. A fresh start with a=b=32'h8000_0000 then gives sum=0, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit built around a single 4-bit CLA slice.
// One operand nibble is processed per cycle, LSB nibble first; latency is
// N+1 edges from accept to the done cycle (N = WIDTH/4).
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only when not busy
//   op_sub          1 = a - b, 0 = a + b + cin
//   a, b            WIDTH-bit operands
//   cin             carry-in for add, ignored for subtract
//   busy            high while nibbles are being processed
//   done            one-cycle result-valid pulse
//   sum, cout       result and MSB carry-out (subtract: 1 = no borrow)
//   zero, ovf       result-is-zero and signed-overflow flags, present only
//                   when NIBBLE_SERIAL_ADDER_FLAGS_EN is defined
//
// WIDTH must be a multiple of 4 and at least 8.

// 4-bit carry-lookahead adder slice.
module carry_look_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum_c,
  output logic       cout_c
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from cin, so no carry ripples through the slice.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum_c  = p ^ c[3:0];
  assign cout_c = c[4];

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             busy_d;
  logic             done_d;

  logic [3:0]       nib_sum_c;
  logic             nib_cout_c;

`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
  logic             nz_q, nz_d;
  logic             zero_d;
  logic             ovf_d;
`endif

  // A/B shift right each cycle, so the slice always sees the low nibble.
  carry_look_adder u_cla (
    .a      (a_q[3:0]),
    .b      (b_q[3:0]),
    .cin    (carry_q),
    .sum_c  (nib_sum_c),
    .cout_c (nib_cout_c)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
      nz_q    <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum     <= sum_d;
      cout    <= cout_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
      nz_q    <= nz_d;
      zero    <= zero_d;
      ovf     <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum;
    cout_d  = cout;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    nz_d    = nz_q;
    zero_d  = zero;
    ovf_d   = ovf;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtract is A + ~B + 1; cin only applies to add.
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          cnt_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
          nz_d    = 1'b0;
`endif
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = nib_cout_c;
        cnt_d   = cnt_q + CW'(1);
        sum_d[{cnt_q, 2'b00} +: 4] = nib_sum_c;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
        nz_d    = nz_q | (|nib_sum_c);
`endif
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = nib_cout_c;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
          zero_d  = ~(nz_q | (|nib_sum_c));
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          ovf_d   = (a_q[3] ^ b_q[3] ^ nib_sum_c[3]) ^ nib_cout_c;
`endif
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

endmodule
